// File: rtl/byte_permutation_pkg.sv
// Shared constants for the AES ShiftRows byte permutation block.
// Holds block geometry, the fixed permutation table and bank identifiers.
package byte_permutation_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BYTE_W      = 8;

    // Output byte k of a block takes input byte PERM[k] (column-major ShiftRows).
    localparam logic [3:0] PERM [BLOCK_BYTES] = '{
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd4,  4'd9,  4'd14, 4'd3,
        4'd8,  4'd13, 4'd2,  4'd7,
        4'd12, 4'd1,  4'd6,  4'd11
    };

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    function automatic logic [3:0] perm_idx(input logic [3:0] k);
        return PERM[k];
    endfunction

endpackage

// File: rtl/byte_bank.sv
// 16x8 register file with asynchronous clear, one write port and one
// combinational read port.
module byte_bank
    import byte_permutation_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [3:0]          waddr,
    input  logic [BYTE_W-1:0]   wdata,
    input  logic [3:0]          raddr,
    output logic [BYTE_W-1:0]   rdata
);

    logic [BYTE_W-1:0] mem [BLOCK_BYTES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/byte_permutation.sv
// Free-running AES ShiftRows permuter: ping-pong banks give a fixed
// 16-cycle latency from byte 0 of a block in to byte 0 of it out.
module byte_permutation
    import byte_permutation_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out
);

    logic [3:0]        cnt;
    bank_sel_t         bank_sel;
    logic [3:0]        rd_idx;
    logic              we_a;
    logic              we_b;
    logic [BYTE_W-1:0] rdata_a;
    logic [BYTE_W-1:0] rdata_b;
    logic [BYTE_W-1:0] rd_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bank_sel <= BANK_A;
        end else begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(BLOCK_BYTES - 1)) begin
                bank_sel <= (bank_sel == BANK_A) ? BANK_B : BANK_A;
            end
        end
    end

    // Active bank is written at slot cnt; the other bank holds the previous
    // block and is read in permuted order.
    always_comb begin
        rd_idx  = perm_idx(cnt);
        we_a    = (bank_sel == BANK_A);
        we_b    = (bank_sel == BANK_B);
        rd_byte = (bank_sel == BANK_A) ? rdata_b : rdata_a;
    end

    byte_bank u_bank_a (
        .clk   (clk),
        .rst   (rst),
        .we    (we_a),
        .waddr (cnt),
        .wdata (data_in),
        .raddr (rd_idx),
        .rdata (rdata_a)
    );

    byte_bank u_bank_b (
        .clk   (clk),
        .rst   (rst),
        .we    (we_b),
        .waddr (cnt),
        .wdata (data_in),
        .raddr (rd_idx),
        .rdata (rdata_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= rd_byte;
        end
    end

endmodule

// File: tb/tb_byte_permutation.sv
// Scoreboard bench for byte_permutation: driver pushes ShiftRows-model
// expectations tagged with their due edge, monitor pops and compares.
module tb_byte_permutation;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   drv_j = 0;
    bit   mon_on = 1'b0;

    byte_permutation dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Monitor: numbers edges with rst low; checks zero output for the first
    // block period, then queued expectations at their due edge.
    initial begin : monitor
        int j;
        int cur;
        exp_t e;
        j = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                j = 0;
            end else begin
                cur = j;
                j++;
                #1;
                if (mon_on) begin
                    while (exp_q.size() > 0 && exp_q[0].due < cur) begin
                        e = exp_q.pop_front();
                        total++; bad++;
                        $display("FAIL missed_output due=%0d now=%0d required=%02h", e.due, cur, e.val);
                    end
                    if (exp_q.size() > 0 && exp_q[0].due == cur) begin
                        e = exp_q.pop_front();
                        total++;
                        if (data_out !== e.val) begin
                            bad++;
                            $display("FAIL out_byte j=%0d actual=%02h required=%02h", cur, data_out, e.val);
                        end
                    end else if (cur < 16) begin
                        total++;
                        if (data_out !== 8'h00) begin
                            bad++;
                            $display("FAIL zero_before_first j=%0d actual=%02h required=00", cur, data_out);
                        end
                    end
                end
            end
        end
    end

    // Drive one byte at the negedge preceding edge drv_j.
    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        @(negedge clk);
        drv_j++;
    endtask

    // Reference ShiftRows: out(r,c) = in(r,(c+r) mod 4), column-major bytes.
    task automatic send_block(input logic [7:0] blk [16]);
        int base;
        exp_t e;
        base = drv_j;
        for (int i = 0; i < 16; i++) send_byte(blk[i]);
        for (int k = 0; k < 16; k++) begin
            int r;
            int c;
            r = k % 4;
            c = k / 4;
            e.due = base + 16 + k;
            e.val = blk[r + 4 * ((c + r) % 4)];
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_clear actual=%02h required=00", data_out);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_j = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [7:0] ref_blk [16];
        logic [7:0] blk     [16];
        logic [7:0] blk2    [16];
        ref_blk = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                    8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_value actual=%02h required=00", data_out);
        end
        mon_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drv_j = 0;

        // Reference stream, then constant ff.
        send_block(ref_blk);
        for (int i = 0; i < 16; i++) blk[i] = 8'hff;
        send_block(blk);
        send_block(blk);

        // Back-to-back blocks, second is first XOR 0x80.
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) blk2[i] = blk[i] ^ 8'h80;
        send_block(blk);
        send_block(blk2);

        // Index stream exposes the table directly.
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        send_block(blk);

        // Random blocks.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
            send_block(blk);
        end
        drain(16);

        // Reset mid-output: edges j=16..20 done, reset before j=21.
        do_reset();
        send_block(ref_blk);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        do_reset();

        // Re-run reference stream after reset.
        send_block(ref_blk);
        drain(16);

        // Reset mid-input block: partial block must be discarded.
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
        do_reset();
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
        send_block(blk);
        drain(16);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_permutation.md
BYTE_PERMUTATION -- requirements
Module: byte_permutation

Interface
REQ-001 The block SHALL have no parameters; byte width is 8 and block size is 16 bytes, both fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 data_in  input  8  one AES state byte per clock, column-major order (byte i = row i mod 4, column i div 4).
REQ-005 data_out  output  8  registered; one ShiftRows-permuted byte per clock.

Function
REQ-006 The block SHALL be free-running with no valid/ready handshake; data_in SHALL be sampled on every rising edge while rst is low.
REQ-007 Cycle j SHALL be the j-th rising edge with rst low, counting from 0; the edge at j=0 SHALL capture input byte 0 of block 0.
REQ-008 Input byte 16n+i SHALL be input byte i of block n; blocks SHALL be contiguous, with no gap cycles.
REQ-009 Output byte k of block n SHALL equal input byte P[k] of block n, where P = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11 (AES ShiftRows: output (r,c) = input (r,(c+r) mod 4)).
REQ-010 Output byte k of block n SHALL be loaded into data_out at edge j = 16(n+1)+k and held for one cycle, giving a fixed latency of 16 cycles from byte 0 in to byte 0 out.
REQ-011 Buffering SHALL be ping-pong: two 16x8 banks and a 4-bit byte counter.
REQ-012 In each cycle the counter value SHALL select the write slot in the active bank and the read slot P[counter] in the other bank.
REQ-013 The banks SHALL swap roles when the counter wraps from 15 to 0.
REQ-014 Simultaneous write of block n+1 and read of block n SHALL never conflict, because they use different banks.
REQ-015 data_out SHALL be 0 from reset until edge j=16.
REQ-016 With a constant data_in, every output after the first block SHALL equal that constant.
REQ-017 The counter and bank select SHALL wrap indefinitely without stalling.

Reset
REQ-018 Asserting rst SHALL immediately clear the counter, bank select, data_out and both banks to 0, independent of clk.
REQ-019 Reset asserted mid-block SHALL discard the partial input block and any block still being output.
REQ-020 After reset release, numbering SHALL restart per REQ-007.

Structure
REQ-021 A shared package SHALL hold BLOCK_BYTES=16, BYTE_W=8 and the constant permutation table P.
REQ-022 One sub-module, byte_bank (16x8 register file with async clear, one write port and one read port), SHALL be instantiated twice.
REQ-023 The top level SHALL contain the counter, bank select, P lookup and data_out register.

Verification
REQ-024 Stream 01,11,22,33,44,55,66,77,88,99,aa,bb,cc,dd,ee,ff from j=0 -> data_out over j=16..31 reads 01,55,aa,ff,44,99,ee,33,88,dd,22,77,cc,11,66,bb.
REQ-025 Same stream, then hold data_in=ff -> data_out=00 for j<16, and ff for every edge from j=32 onward.
REQ-026 Two back-to-back distinct blocks (second block = first block XOR 0x80) -> second permuted block appears at j=32..47 with no gap or corruption.
REQ-027 Assert rst asynchronously mid-output (e.g. between edges j=20 and j=21) -> data_out=00 immediately; after release, the REQ-024 stream re-run reproduces the REQ-024 output at new j=16..31.
REQ-028 Stream with data_in = byte index (00..0f) -> outputs 00,05,0a,0f,04,09,0e,03,08,0d,02,07,0c,01,06,0b, confirming table P exactly.
